// File: rtl/cache_mesi_array_ctrl_pkg.sv
// Shared MESI coherence types, C-line encodings and the line transition function
// used by the set-associative state-array controller.
package cache_mesi_array_ctrl_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef mesi_t mesi_struct;

  typedef enum logic [2:0] {
    MSG_READ_REQ_L1_D     = 3'd0,
    MSG_READ_REQ_L1_I     = 3'd1,
    MSG_WRITE_REQ_L1_D    = 3'd2,
    MSG_SNOOP_INVALID_CMD = 3'd3,
    MSG_SNOOP_READ_REQ    = 3'd4,
    MSG_SNOOP_WRITE_REQ   = 3'd5,
    MSG_SNOOP_READ_WITH_M = 3'd6,
    MSG_NOP               = 3'd7
  } n_struct;

  typedef enum logic [2:0] {
    BUS_NULL       = 3'd0,
    BUS_READ       = 3'd1,
    BUS_WRITE      = 3'd2,
    BUS_INVALIDATE = 3'd3,
    BUS_RWIM       = 3'd4
  } bus_struct;

  typedef enum logic [2:0] {
    L2_NULLMSG        = 3'd0,
    L2_SENDLINE       = 3'd1,
    L2_GETLINE        = 3'd2,
    L2_INVALIDATELINE = 3'd3,
    L2_EVICTLINE      = 3'd4
  } l2tol1_struct;

  // Encodings of the shared C lines driven/sampled between caches.
  localparam logic [1:0] HIT     = 2'b00;
  localparam logic [1:0] HITM    = 2'b01;
  localparam logic [1:0] NOHIT_1 = 2'b10;
  localparam logic [1:0] NOHIT_2 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUS_WAIT = 2'd1,
    ST_SWEEP    = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    mesi_t        nxt;
    bus_struct    bus;
    l2tol1_struct l2tol1;
    logic [1:0]   c_out;
  } mesi_rsp_t;

  function automatic logic is_snoop(input n_struct msg);
    return msg inside {MSG_SNOOP_INVALID_CMD, MSG_SNOOP_READ_REQ,
                       MSG_SNOOP_WRITE_REQ, MSG_SNOOP_READ_WITH_M};
  endfunction

  function automatic logic is_l1_read(input n_struct msg);
    return msg inside {MSG_READ_REQ_L1_D, MSG_READ_REQ_L1_I};
  endfunction

  // Unlisted (state, message) pairs keep the state and issue nothing.
  function automatic mesi_rsp_t mesi_next(input mesi_t prev, input n_struct msg,
                                          input logic [1:0] c_in);
    mesi_rsp_t r;
    r.nxt    = prev;
    r.bus    = BUS_NULL;
    r.l2tol1 = L2_NULLMSG;
    r.c_out  = NOHIT_1;
    if (is_snoop(msg)) begin
      case (prev)
        MESI_M:         r.c_out = HITM;
        MESI_E, MESI_S: r.c_out = HIT;
        default:        r.c_out = NOHIT_1;
      endcase
    end
    case (prev)
      MESI_M: begin
        if (is_l1_read(msg) || msg == MSG_WRITE_REQ_L1_D) begin
          r.l2tol1 = L2_SENDLINE;
        end else if (msg == MSG_SNOOP_READ_REQ) begin
          r.nxt = MESI_S;
          r.bus = BUS_WRITE;
        end else if (msg == MSG_SNOOP_READ_WITH_M || msg == MSG_SNOOP_WRITE_REQ) begin
          r.nxt    = MESI_I;
          r.bus    = BUS_WRITE;
          r.l2tol1 = L2_EVICTLINE;
        end
      end
      MESI_E: begin
        if (is_l1_read(msg)) begin
          r.l2tol1 = L2_SENDLINE;
        end else if (msg == MSG_WRITE_REQ_L1_D) begin
          r.nxt    = MESI_M;
          r.l2tol1 = L2_GETLINE;
        end else if (msg == MSG_SNOOP_READ_REQ) begin
          r.nxt = MESI_S;
        end else if (msg == MSG_SNOOP_READ_WITH_M || msg == MSG_SNOOP_WRITE_REQ) begin
          r.nxt    = MESI_I;
          r.l2tol1 = L2_INVALIDATELINE;
        end
      end
      MESI_S: begin
        if (is_l1_read(msg)) begin
          r.l2tol1 = L2_SENDLINE;
        end else if (msg == MSG_WRITE_REQ_L1_D) begin
          r.nxt    = MESI_M;
          r.bus    = BUS_INVALIDATE;
          r.l2tol1 = L2_GETLINE;
        end else if (msg == MSG_SNOOP_READ_WITH_M || msg == MSG_SNOOP_WRITE_REQ ||
                     msg == MSG_SNOOP_INVALID_CMD) begin
          r.nxt    = MESI_I;
          r.l2tol1 = L2_INVALIDATELINE;
        end
      end
      default: begin
        if (is_l1_read(msg)) begin
          r.nxt    = (c_in == HIT || c_in == HITM) ? MESI_S : MESI_E;
          r.bus    = BUS_READ;
          r.l2tol1 = L2_SENDLINE;
        end else if (msg == MSG_WRITE_REQ_L1_D) begin
          r.nxt    = MESI_M;
          r.bus    = BUS_RWIM;
          r.l2tol1 = L2_SENDLINE;
        end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cache_mesi_line_next.sv
// Combinational MESI transition table for one cache line: previous state plus
// command and sampled C lines give next state, bus op, L1 message and snoop result.
module cache_mesi_line_next
  import cache_mesi_array_ctrl_pkg::*;
(
  input  mesi_t      prev_i,
  input  n_struct    msg_i,
  input  logic [1:0] c_in_i,
  output mesi_rsp_t  rsp_o
);

  assign rsp_o = mesi_next(prev_i, msg_i, c_in_i);

endmodule

// File: rtl/cache_mesi_array_ctrl.sv
// MESI controller for a SETS x WAYS L2 state array: one request per cycle, registered
// response held across bus operations, and a one-set-per-cycle flash-invalidate sweep.
module cache_mesi_array_ctrl
  import cache_mesi_array_ctrl_pkg::*;
#(
  parameter int SETS = 16,
  parameter int WAYS = 8,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SET_W-1:0]   req_set,
  input  logic [WAY_W-1:0]   req_way,
  input  n_struct            req_msg,
  input  logic [1:0]         req_c_in,
  input  logic               clear_req,
  output logic               clear_done,
  output logic               rsp_valid,
  output mesi_struct         rsp_prev_state,
  output mesi_struct         rsp_state,
  output bus_struct          rsp_bus,
  output l2tol1_struct       rsp_l2tol1,
  output logic [1:0]         rsp_c_out,
  input  logic               bus_ack,
  output ctrl_state_t        dbg_state
);

  mesi_t            arr_q [SETS][WAYS];
  ctrl_state_t      st_q, st_d;
  logic [SET_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  mesi_rsp_t        rsp_q, rsp_d;
  mesi_t            prev_q, prev_d;
  logic             clear_done_q, clear_done_d;

  mesi_t            cur_state;
  mesi_rsp_t        line_rsp;
  logic             bus_wait;
  logic             accept;
  logic             clear_start;

  assign cur_state = arr_q[req_set][req_way];

  cache_mesi_line_next u_line_next (
    .prev_i (cur_state),
    .msg_i  (req_msg),
    .c_in_i (req_c_in),
    .rsp_o  (line_rsp)
  );

  // Handshake: a request transfers on a posedge where req_valid && req_ready; the
  // response follows one cycle later and, when it carries a bus op, is held with
  // req_ready low until the cycle bus_ack is high (a new request may transfer then).
  assign bus_wait    = (st_q == ST_BUS_WAIT) && !bus_ack;
  assign req_ready   = (st_q != ST_SWEEP) && !clear_req && !bus_wait;
  assign accept      = req_valid && req_ready;
  assign clear_start = clear_req && (st_q != ST_SWEEP) && !bus_wait;

  always_comb begin
    st_d         = st_q;
    sweep_cnt_d  = sweep_cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_d        = rsp_q;
    prev_d       = prev_q;
    clear_done_d = 1'b0;
    case (st_q)
      ST_IDLE, ST_BUS_WAIT: begin
        if (st_q == ST_IDLE || bus_ack) begin
          rsp_valid_d = 1'b0;
          st_d        = ST_IDLE;
        end
        if (clear_start) begin
          st_d        = ST_SWEEP;
          sweep_cnt_d = '0;
        end else if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_d       = line_rsp;
          prev_d      = cur_state;
          st_d        = (line_rsp.bus != BUS_NULL) ? ST_BUS_WAIT : ST_IDLE;
        end
      end
      ST_SWEEP: begin
        sweep_cnt_d = sweep_cnt_q + 1'b1;
        if (sweep_cnt_q == SET_W'(SETS - 1)) begin
          st_d         = ST_IDLE;
          clear_done_d = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      st_q         <= ST_IDLE;
      sweep_cnt_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_q        <= '{nxt: MESI_I, bus: BUS_NULL, l2tol1: L2_NULLMSG, c_out: NOHIT_1};
      prev_q       <= MESI_I;
      clear_done_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      sweep_cnt_q  <= sweep_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_q        <= rsp_d;
      prev_q       <= prev_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Sweep and accepted requests never coincide: req_ready is low throughout the sweep.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          arr_q[s[SET_W-1:0]][w[WAY_W-1:0]] <= MESI_I;
        end
      end
    end else if (st_q == ST_SWEEP) begin
      for (int w = 0; w < WAYS; w++) begin
        arr_q[sweep_cnt_q][w[WAY_W-1:0]] <= MESI_I;
      end
    end else if (accept) begin
      arr_q[req_set][req_way] <= line_rsp.nxt;
    end
  end

  always @(posedge clk) begin
    if (rstb && accept) begin
      assert (int'(req_way) < WAYS);
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_prev_state = prev_q;
  assign rsp_state      = rsp_q.nxt;
  assign rsp_bus        = rsp_q.bus;
  assign rsp_l2tol1     = rsp_q.l2tol1;
  assign rsp_c_out      = rsp_q.c_out;
  assign clear_done     = clear_done_q;
  assign dbg_state      = st_q;

endmodule

// File: tb/tb_cache_mesi_array_ctrl.sv
// Directed bench for cache_mesi_array_ctrl: responses are checked against an
// expected queue filled at request acceptance, plus stall/sweep/reset checks.
module tb_cache_mesi_array_ctrl;
  import cache_mesi_array_ctrl_pkg::*;

  localparam int SETS = 16;
  localparam int WAYS = 8;

  logic         clk;
  logic         rstb;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_set;
  logic [2:0]   req_way;
  n_struct      req_msg;
  logic [1:0]   req_c_in;
  logic         clear_req;
  logic         clear_done;
  logic         rsp_valid;
  mesi_struct   rsp_prev_state;
  mesi_struct   rsp_state;
  bus_struct    rsp_bus;
  l2tol1_struct rsp_l2tol1;
  logic [1:0]   rsp_c_out;
  logic         bus_ack;
  ctrl_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [11:0] exp_q[$];

  cache_mesi_array_ctrl #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk            (clk),
    .rstb           (rstb),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_set        (req_set),
    .req_way        (req_way),
    .req_msg        (req_msg),
    .req_c_in       (req_c_in),
    .clear_req      (clear_req),
    .clear_done     (clear_done),
    .rsp_valid      (rsp_valid),
    .rsp_prev_state (rsp_prev_state),
    .rsp_state      (rsp_state),
    .rsp_bus        (rsp_bus),
    .rsp_l2tol1     (rsp_l2tol1),
    .rsp_c_out      (rsp_c_out),
    .bus_ack        (bus_ack),
    .dbg_state      (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pk(input mesi_t p, input mesi_t n, input bus_struct b,
                                     input l2tol1_struct l, input logic [1:0] c);
    return {p, n, b, l, c};
  endfunction

  // Scoreboard: a response is consumed on the edge where it is valid and either
  // carries no bus op or is being acknowledged.
  always @(negedge clk) begin
    if (rstb && rsp_valid && (rsp_bus == BUS_NULL || bus_ack)) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected_qsize", 32'(exp_q.size()), 32'(1));
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("rsp", 32'({rsp_prev_state, rsp_state, rsp_bus, rsp_l2tol1, rsp_c_out}), 32'(e));
      end
    end
  end

  // Driver: present a request, wait (bounded) for ready, push expectation at transfer.
  task automatic issue(input int s, input int w, input n_struct m, input logic [1:0] c,
                       input logic [11:0] e);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_set   = 4'(s);
    req_way   = 3'(w);
    req_msg   = m;
    req_c_in  = c;
    #1;
    while (!req_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_ready", 32'(req_ready), 32'(1));
    if (req_ready) begin
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),      32'(0));
    chk({tag, "_prev"},       32'(rsp_prev_state), 32'(MESI_I));
    chk({tag, "_state"},      32'(rsp_state),      32'(MESI_I));
    chk({tag, "_bus"},        32'(rsp_bus),        32'(BUS_NULL));
    chk({tag, "_l2tol1"},     32'(rsp_l2tol1),     32'(L2_NULLMSG));
    chk({tag, "_c_out"},      32'(rsp_c_out),      32'(NOHIT_1));
    chk({tag, "_clear_done"}, 32'(clear_done),     32'(0));
  endtask

  initial begin
    int c0;
    rstb      = 1'b0;
    req_valid = 1'b0;
    req_set   = '0;
    req_way   = '0;
    req_msg   = MSG_NOP;
    req_c_in  = NOHIT_1;
    clear_req = 1'b0;
    bus_ack   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // Read miss with bus stall
    bus_ack = 1'b0;
    issue(3, 2, MSG_READ_REQ_L1_D, NOHIT_1, pk(MESI_I, MESI_E, BUS_READ, L2_SENDLINE, NOHIT_1));
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(rsp_valid), 32'(1));
      chk("stall_state", 32'(rsp_state), 32'(MESI_E));
      chk("stall_bus",   32'(rsp_bus),   32'(BUS_READ));
      chk("stall_ready", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;
    end
    bus_ack = 1'b1;
    #1;
    chk("ack_ready", 32'(req_ready), 32'(1));
    @(posedge clk);
    #1;
    chk("ack_valid_drop", 32'(rsp_valid), 32'(0));

    // E -> M pulse, then snoop read from M
    issue(3, 2, MSG_WRITE_REQ_L1_D, NOHIT_1, pk(MESI_E, MESI_M, BUS_NULL, L2_GETLINE, NOHIT_1));
    chk("pulse_valid_hi", 32'(rsp_valid), 32'(1));
    @(posedge clk);
    #1;
    chk("pulse_valid_lo", 32'(rsp_valid), 32'(0));
    issue(3, 2, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_M, MESI_S, BUS_WRITE, L2_NULLMSG, HITM));

    // Shared fill, upgrade and eviction on set 0 / way 0
    issue(0, 0, MSG_READ_REQ_L1_D, HITM, pk(MESI_I, MESI_S, BUS_READ, L2_SENDLINE, NOHIT_1));
    issue(0, 0, MSG_WRITE_REQ_L1_D, NOHIT_1, pk(MESI_S, MESI_M, BUS_INVALIDATE, L2_GETLINE, NOHIT_1));
    issue(0, 0, MSG_SNOOP_WRITE_REQ, NOHIT_1, pk(MESI_M, MESI_I, BUS_WRITE, L2_EVICTLINE, HITM));

    // Remaining transitions
    issue(1, 1, MSG_READ_REQ_L1_I, NOHIT_2, pk(MESI_I, MESI_E, BUS_READ, L2_SENDLINE, NOHIT_1));
    issue(1, 1, MSG_SNOOP_READ_WITH_M, NOHIT_1, pk(MESI_E, MESI_I, BUS_NULL, L2_INVALIDATELINE, HIT));
    issue(2, 2, MSG_READ_REQ_L1_D, HIT, pk(MESI_I, MESI_S, BUS_READ, L2_SENDLINE, NOHIT_1));
    issue(2, 2, MSG_SNOOP_INVALID_CMD, NOHIT_1, pk(MESI_S, MESI_I, BUS_NULL, L2_INVALIDATELINE, HIT));
    issue(2, 2, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_I, MESI_I, BUS_NULL, L2_NULLMSG, NOHIT_1));
    issue(3, 2, MSG_NOP, NOHIT_1, pk(MESI_S, MESI_S, BUS_NULL, L2_NULLMSG, NOHIT_1));

    // Back-to-back on set 5 / way 7
    c0 = cyc;
    issue(5, 7, MSG_READ_REQ_L1_D, NOHIT_1, pk(MESI_I, MESI_E, BUS_READ, L2_SENDLINE, NOHIT_1));
    issue(5, 7, MSG_WRITE_REQ_L1_D, NOHIT_1, pk(MESI_E, MESI_M, BUS_NULL, L2_GETLINE, NOHIT_1));
    issue(5, 7, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_M, MESI_S, BUS_WRITE, L2_NULLMSG, HITM));
    chk("b2b_cycles", 32'(cyc - c0), 32'(3));
    issue(5, 7, MSG_WRITE_REQ_L1_D, NOHIT_1, pk(MESI_S, MESI_M, BUS_INVALIDATE, L2_GETLINE, NOHIT_1));
    issue(5, 7, MSG_READ_REQ_L1_I, NOHIT_1, pk(MESI_M, MESI_M, BUS_NULL, L2_SENDLINE, NOHIT_1));

    // Flash clear with a colliding request
    issue(1, 0, MSG_WRITE_REQ_L1_D, NOHIT_1, pk(MESI_I, MESI_M, BUS_RWIM, L2_SENDLINE, NOHIT_1));
    issue(2, 3, MSG_WRITE_REQ_L1_D, NOHIT_1, pk(MESI_I, MESI_M, BUS_RWIM, L2_SENDLINE, NOHIT_1));
    issue(9, 5, MSG_WRITE_REQ_L1_D, NOHIT_1, pk(MESI_I, MESI_M, BUS_RWIM, L2_SENDLINE, NOHIT_1));
    issue(15, 7, MSG_WRITE_REQ_L1_D, NOHIT_1, pk(MESI_I, MESI_M, BUS_RWIM, L2_SENDLINE, NOHIT_1));
    clear_req = 1'b1;
    req_valid = 1'b1;
    req_set   = 4'd4;
    req_way   = 3'd4;
    req_msg   = MSG_WRITE_REQ_L1_D;
    req_c_in  = NOHIT_1;
    #1;
    chk("clear_blocks_req", 32'(req_ready), 32'(0));
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      chk($sformatf("sweep_ready_%0d", i), 32'(req_ready), 32'(0));
      chk($sformatf("sweep_done_%0d", i),  32'(clear_done), 32'(0));
      @(posedge clk);
      #1;
    end
    chk("clear_done_pulse", 32'(clear_done), 32'(1));
    chk("clear_ready_back", 32'(req_ready), 32'(1));
    exp_q.push_back(pk(MESI_I, MESI_M, BUS_RWIM, L2_SENDLINE, NOHIT_1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("clear_done_once", 32'(clear_done), 32'(0));
    issue(1, 0, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_I, MESI_I, BUS_NULL, L2_NULLMSG, NOHIT_1));
    issue(2, 3, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_I, MESI_I, BUS_NULL, L2_NULLMSG, NOHIT_1));
    issue(9, 5, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_I, MESI_I, BUS_NULL, L2_NULLMSG, NOHIT_1));
    issue(15, 7, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_I, MESI_I, BUS_NULL, L2_NULLMSG, NOHIT_1));
    issue(5, 7, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_I, MESI_I, BUS_NULL, L2_NULLMSG, NOHIT_1));
    issue(4, 4, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_M, MESI_S, BUS_WRITE, L2_NULLMSG, HITM));

    // Reset in the middle of a sweep
    issue(6, 6, MSG_WRITE_REQ_L1_D, NOHIT_1, pk(MESI_I, MESI_M, BUS_RWIM, L2_SENDLINE, NOHIT_1));
    @(posedge clk);
    #1;
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midsweep_state", 32'(dbg_state), 32'(ST_SWEEP));
    rstb = 1'b0;
    #1;
    chk_reset("sweep_rst");
    chk("sweep_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rstb = 1'b1;
    issue(6, 6, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_I, MESI_I, BUS_NULL, L2_NULLMSG, NOHIT_1));
    issue(4, 4, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_I, MESI_I, BUS_NULL, L2_NULLMSG, NOHIT_1));

    // Reset during a bus wait; the held response is abandoned
    bus_ack = 1'b0;
    issue(7, 1, MSG_WRITE_REQ_L1_D, NOHIT_1, pk(MESI_I, MESI_M, BUS_RWIM, L2_SENDLINE, NOHIT_1));
    @(posedge clk);
    #1;
    chk("buswait_valid", 32'(rsp_valid), 32'(1));
    chk("buswait_ready", 32'(req_ready), 32'(0));
    rstb = 1'b0;
    #1;
    chk_reset("bus_rst");
    exp_q.delete();
    @(posedge clk);
    #1;
    rstb    = 1'b1;
    bus_ack = 1'b1;
    @(posedge clk);
    #1;
    issue(7, 1, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_I, MESI_I, BUS_NULL, L2_NULLMSG, NOHIT_1));
    issue(0, 0, MSG_SNOOP_READ_REQ, NOHIT_1, pk(MESI_I, MESI_I, BUS_NULL, L2_NULLMSG, NOHIT_1));

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
